// File: rtl/ram_loader_pkg.sv
// Shared types and default framing bytes for the serial RAM loader.
package ram_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAhi,
    StAlo,
    StLhi,
    StLlo,
    StData,
    StCsum,
    StResp
  } state_e;

  localparam logic [7:0] DefaultSync = 8'h4C;
  localparam logic [7:0] DefaultAck  = 8'h06;
  localparam logic [7:0] DefaultNak  = 8'h15;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte timeout: reloads on load, counts down while enabled, flags expiry at zero.
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CntWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Loading N-1 makes expiry fire on the Nth idle cycle after the reload.
  localparam logic [CntWidth-1:0] LoadVal = CntWidth'(TIMEOUT_CYCLES - 1);

  logic [CntWidth-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= LoadVal;
    end else if (enable && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = enable && (cnt_q == '0);

endmodule

// File: rtl/ram_loader.sv
// Serial frame to RAM loader: parses SYNC/ADDR/LEN/DATA/CSUM and answers ACK or NAK.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 13,
  parameter logic [7:0]  SYNC_BYTE      = DefaultSync,
  parameter logic [7:0]  ACK_BYTE       = DefaultAck,
  parameter logic [7:0]  NAK_BYTE       = DefaultNak,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_w_en,
  output logic [7:0]            ram_din,
  output logic                  busy,
  output logic                  error
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [15:0]           len_q, len_d;
  logic [7:0]            sum_q, sum_d;
  logic [7:0]            hi_q, hi_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  w_en_q, w_en_d;
  logic [7:0]            din_q, din_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                  error_q, error_d;
  logic                  busy_q;
  logic                  active;
  logic                  expire;

  assign active = (state_q != StIdle) && (state_q != StResp);

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .load  (rx_valid || !active),
    .enable(active),
    .expire(expire)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    len_d     = len_q;
    sum_d     = sum_q;
    hi_d      = hi_q;
    tx_data_d = tx_data_q;
    w_en_d    = 1'b0;
    din_d     = din_q;
    waddr_d   = waddr_q;
    error_d   = error_q;

    case (state_q)
      StIdle: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = StAhi;
          error_d = 1'b0;
          sum_d   = '0;
        end
      end
      StAhi: begin
        if (rx_valid) begin
          hi_d    = rx_data;
          state_d = StAlo;
        end
      end
      StAlo: begin
        if (rx_valid) begin
          ptr_d   = ADDR_WIDTH'({hi_q, rx_data});
          state_d = StLhi;
        end
      end
      StLhi: begin
        if (rx_valid) begin
          hi_d    = rx_data;
          state_d = StLlo;
        end
      end
      StLlo: begin
        if (rx_valid) begin
          len_d   = {hi_q, rx_data};
          state_d = ({hi_q, rx_data} == 16'h0) ? StCsum : StData;
        end
      end
      StData: begin
        if (rx_valid) begin
          w_en_d  = 1'b1;
          din_d   = rx_data;
          waddr_d = ptr_q;
          ptr_d   = ptr_q + 1'b1;
          sum_d   = sum_q + rx_data;
          len_d   = len_q - 16'd1;
          if (len_q == 16'd1) begin
            state_d = StCsum;
          end
        end
      end
      StCsum: begin
        if (rx_valid) begin
          if (rx_data == sum_q) begin
            tx_data_d = ACK_BYTE;
          end else begin
            tx_data_d = NAK_BYTE;
            error_d   = 1'b1;
          end
          state_d = StResp;
        end
      end
      StResp: begin
        if (tx_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A byte arriving on the expiry cycle wins; the timer reloads on it.
    if (expire && !rx_valid) begin
      state_d   = StResp;
      tx_data_d = NAK_BYTE;
      error_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      len_q     <= '0;
      sum_q     <= '0;
      hi_q      <= '0;
      tx_data_q <= '0;
      w_en_q    <= 1'b0;
      din_q     <= '0;
      waddr_q   <= '0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      hi_q      <= hi_d;
      tx_data_q <= tx_data_d;
      w_en_q    <= w_en_d;
      din_q     <= din_d;
      waddr_q   <= waddr_d;
      error_q   <= error_d;
      busy_q    <= (state_d != StIdle);
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = (state_q == StResp);
  assign ram_address = waddr_q;
  assign ram_w_en    = w_en_q;
  assign ram_din     = din_q;
  assign busy        = busy_q;
  assign error       = error_q;

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: directed frames plus randomized frames against a frame model.
module tb_ram_loader;

  localparam int unsigned Timeout = 50;
  localparam logic [7:0]  Sync    = 8'h4C;
  localparam logic [7:0]  Ack     = 8'h06;
  localparam logic [7:0]  Nak     = 8'h15;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [12:0] ram_address;
  logic        ram_w_en;
  logic [7:0]  ram_din;
  logic        busy;
  logic        error;

  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  logic [7:0]  frm[$];

  ram_loader #(
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ram_address(ram_address),
    .ram_w_en   (ram_w_en),
    .ram_din    (ram_din),
    .busy       (busy),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_w_en) wr_cnt <= wr_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Strobe one byte; returns 1 time unit after the sampling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic handle_resp(input logic [7:0] exp_byte, input logic exp_err, input int hold,
                             input bit noise);
    int w0;
    check_eq("resp_valid", tx_valid, 1);
    check_eq("resp_byte", tx_data, exp_byte);
    check_eq("resp_error", error, exp_err);
    check_eq("resp_busy", busy, 1);
    w0 = wr_cnt;
    for (int k = 0; k < hold; k++) begin
      idle(1);
      if (noise && (k % 3 == 0)) send_byte((k == 0) ? Sync : 8'($urandom));
      check_eq("hold_valid", tx_valid, 1);
      check_eq("hold_byte", tx_data, exp_byte);
    end
    if (noise) check_eq("noise_writes", wr_cnt - w0, 0);
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    check_eq("post_valid", tx_valid, 0);
    check_eq("post_busy", busy, 0);
    check_eq("post_error", error, exp_err);
    idle(2);
  endtask

  // Reference model: each data byte lands at start+i mod 8192; response from the data-byte sum.
  task automatic run_frame(input int gap_max, input int hold, input bit noise);
    int         a;
    int         len;
    int         last;
    int         w0;
    logic [7:0] sum;
    a    = {frm[1], frm[2]} % 8192;
    len  = {frm[3], frm[4]};
    last = frm.size() - 1;
    sum  = 8'h00;
    w0   = wr_cnt;
    for (int i = 0; i <= last; i++) begin
      send_byte(frm[i]);
      if (i == 0) begin
        check_eq("sync_busy", busy, 1);
        check_eq("sync_err_clr", error, 0);
      end
      if (i >= 5 && i < 5 + len) begin
        check_eq("w_en", ram_w_en, 1);
        check_eq("w_addr", ram_address, a[12:0]);
        check_eq("w_din", ram_din, frm[i]);
        a   = (a + 1) % 8192;
        sum = sum + frm[i];
      end
      if (i < last) idle($urandom_range(gap_max, 1));
    end
    check_eq("w_count", wr_cnt - w0, len);
    handle_resp((frm[last] == sum) ? Ack : Nak, frm[last] != sum, hold, noise);
  endtask

  initial begin
    int         w0;
    int         len;
    logic [7:0] ahi, alo, s;

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_outs", {busy, tx_valid, ram_w_en, error}, 0);
    check_eq("rst_data", {tx_data, ram_din, 3'b000, ram_address}, 0);
    rst = 1'b0;
    idle(2);
    check_eq("idle_busy", busy, 0);

    // Non-sync bytes in idle are ignored
    send_byte(8'h55);
    idle(2);
    check_eq("junk_busy", busy, 0);

    frm = {8'h4C, 8'h02, 8'h00, 8'h00, 8'h03, 8'hA9, 8'h01, 8'h8D, 8'h37};
    run_frame(3, 2, 0);
    frm = {8'h4C, 8'h02, 8'h00, 8'h00, 8'h03, 8'hA9, 8'h01, 8'h8D, 8'h38};
    run_frame(3, 2, 0);
    frm = {8'h4C, 8'h1F, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
    run_frame(2, 1, 0);
    frm = {8'h4C, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(2, 0, 0);
    frm = {8'h4C, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
    run_frame(2, 0, 0);
    frm = {8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
    frm[0] = Sync;
    run_frame(4, 0, 0);

    // Timeout: the 50th idle cycle after the last byte aborts to a NAK
    frm = {8'h4C, 8'h00, 8'h10, 8'h00, 8'h04, 8'hAA};
    for (int i = 0; i < 6; i++) begin
      send_byte(frm[i]);
      if (i < 5) idle(2);
    end
    check_eq("to_w_en", ram_w_en, 1);
    check_eq("to_w_addr", ram_address, 13'h0010);
    check_eq("to_w_din", ram_din, 8'hAA);
    idle(Timeout - 1);
    check_eq("to_early", tx_valid, 0);
    idle(1);
    handle_resp(Nak, 1'b1, 0, 0);

    // Back-pressure with ignored rx bytes during the response
    frm = {8'h4C, 8'h02, 8'h00, 8'h00, 8'h03, 8'hA9, 8'h01, 8'h8D, 8'h37};
    run_frame(2, 20, 1);

    // Reset in the middle of the data phase
    frm = {8'h4C, 8'h00, 8'h40, 8'h00, 8'h05, 8'h01, 8'h02};
    for (int i = 0; i < 7; i++) begin
      send_byte(frm[i]);
      if (i < 6) idle(1);
    end
    check_eq("pre_rst_w_en", ram_w_en, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_mid_outs", {busy, tx_valid, ram_w_en, error}, 0);
    check_eq("rst_mid_data", {tx_data, ram_din, 3'b000, ram_address}, 0);
    w0 = wr_cnt;
    for (int i = 3; i <= 5; i++) begin
      idle(1);
      send_byte(8'(i));
    end
    idle(3);
    check_eq("rst_no_writes", wr_cnt - w0, 0);
    check_eq("rst_idle_busy", busy, 0);

    for (int n = 0; n < 30; n++) begin
      ahi = 8'($urandom);
      alo = 8'($urandom);
      if (n % 4 == 0) begin
        ahi[4:0] = 5'h1F;
        alo      = 8'hF8 | 8'($urandom_range(7, 0));
      end
      len = $urandom_range(20, 0);
      frm = {Sync, ahi, alo, 8'h00, 8'(len)};
      s   = 8'h00;
      for (int i = 0; i < len; i++) begin
        frm.push_back(8'($urandom));
        s = s + frm[5 + i];
      end
      if ($urandom_range(3, 0) == 0) s = s + 8'($urandom_range(255, 1));
      frm.push_back(s);
      run_frame(6, $urandom_range(5, 0), n % 5 == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
